// File: rtl/fetch_queue.sv
// Instruction fetch queue: a circular FIFO of {pc, instr} entries between fetch and decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [WIDTH-1:0]       in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_pc,
  output logic [WIDTH-1:0]       out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  localparam logic [WIDTH-1:0] NOP  = WIDTH'(32'h0000_0013);

  logic [WIDTH-1:0] mem_pc    [DEPTH];
  logic [WIDTH-1:0] mem_instr [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_w, head_valid_w, byp_w, push_w, pop_w, store_w, deq_w;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; ready never depends on the partner's valid, and flush/reset kill both sides.
  always_comb begin
    empty_w      = (count_q == '0);
    head_valid_w = !empty_w && !flush;
    in_ready     = (count_q < FULL) && !flush && !reset;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_w        = empty_w && in_valid && !flush && !reset;
`else
    byp_w        = 1'b0;
`endif
    out_valid    = head_valid_w || byp_w;
    out_pc       = '0;
    out_instr    = NOP;
    if (head_valid_w) begin
      out_pc    = mem_pc[rd_ptr_q];
      out_instr = mem_instr[rd_ptr_q];
    end else if (byp_w) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
    push_w  = in_valid && in_ready;
    pop_w   = out_valid && out_ready;
    // A bypassed instruction that decode takes immediately never touches storage.
    store_w = push_w && !(byp_w && out_ready);
    deq_w   = pop_w && !byp_w;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store_w) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq_w)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({store_w, deq_w})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (store_w && !flush) begin
      mem_pc[wr_ptr_q]    <= in_pc;
      mem_instr[wr_ptr_q] <= in_instr;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue with a queue-based reference model.
// Build with FETCH_QUEUE_BYPASS_EN defined to check the bypass variant.
module tb_fetch_queue;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_pc = '0;
  logic [W-1:0]  in_instr = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_instr;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];

  fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard / monitor: compares at the falling edge, then advances the model
  always @(negedge clk) begin
    logic           exp_v, exp_rdy, pop, push, byp;
    logic [W-1:0]   exp_pc, exp_ins;
    if (reset) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_out_pc",    64'(out_pc),    64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'(NOP));
      exp_q.delete();
    end else begin
      exp_rdy = (exp_q.size() < D) && !flush;
      byp     = 1'b0;
      exp_v   = 1'b0;
      exp_pc  = '0;
      exp_ins = NOP;
      if (!flush && exp_q.size() > 0) begin
        exp_v   = 1'b1;
        exp_pc  = exp_q[0][2*W-1:W];
        exp_ins = exp_q[0][W-1:0];
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (!flush && in_valid) begin
        byp     = 1'b1;
        exp_v   = 1'b1;
        exp_pc  = in_pc;
        exp_ins = in_instr;
      end
`endif
      chk("in_ready",  64'(in_ready),  64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      chk("out_pc",    64'(out_pc),    64'(exp_pc));
      chk("out_instr", 64'(out_instr), 64'(exp_ins));
      chk("count",     64'(count),     64'(exp_q.size()));
      if (flush) begin
        exp_q.delete();
      end else begin
        pop  = exp_v && out_ready;
        push = in_valid && exp_rdy;
        if (!(byp && pop)) begin
          if (pop)  void'(exp_q.pop_front());
          if (push) exp_q.push_back({in_pc, in_instr});
        end
      end
    end
  end

  // driver: inputs applied just after a rising edge and held for one cycle
  task automatic step(input logic v, input logic [W-1:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = pc ^ 32'hA5A5_0000;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // fill to full while stalled, then drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // steady streaming at occupancy two
    for (int i = 0; i < 2; i++) step(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
    drain();

    // flush at occupancy three with a simultaneous push
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h999, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset in the middle of a cycle with two entries queued
    for (int i = 0; i < 2; i++) step(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 chk("pre_async_valid", 64'(out_valid), 64'd1);
    chk("pre_async_count", 64'(count), 64'd2);
    #1 reset = 1'b1;
    #1 chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);

    // empty queue: bypass or one-cycle latency depending on build
    step(1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // pointer wrap with steady traffic
    step(1'b1, 32'h600, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h604 + 32'(i * 4), 1'b1, 1'b0);
    drain();

    // randomized traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the width of the PC and instruction fields.
REQ-002 SHALL have parameter DEPTH, default 4, giving the entry count; legal values are 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the fetch side presents an instruction.
REQ-006 SHALL have port in_pc, input, WIDTH bits: PC of the presented instruction.
REQ-007 SHALL have port in_instr, input, WIDTH bits: instruction word from instruction memory.
REQ-008 SHALL have port in_ready, output, 1 bit: the queue accepts an instruction this cycle.
REQ-009 SHALL have port flush, input, 1 bit: discard all queued and incoming instructions (taken branch or jump).
REQ-010 SHALL have port out_ready, input, 1 bit: the decode stage enable, i.e. the inverse of the decode stall.
REQ-011 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-012 SHALL have port out_pc, output, WIDTH bits: PC of the head entry.
REQ-013 SHALL have port out_instr, output, WIDTH bits: instruction of the head entry.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 SHALL be a circular FIFO of {pc, instr} entries with read and write pointers that wrap modulo DEPTH.
REQ-016 SHALL push when in_valid and in_ready are both high at a rising clk edge.
REQ-017 SHALL pop when out_valid and out_ready are both high at a rising clk edge.
REQ-018 SHALL drive in_ready = (count < DEPTH) and not flush; in_ready SHALL NOT depend on out_ready.
REQ-019 SHALL drive out_valid = (count != 0) and not flush, in the non-bypass build.
REQ-020 SHALL drive out_pc = 0 and out_instr = 32'h00000013 (NOP, addi x0,x0,0) whenever out_valid is low.
REQ-021 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL permit a simultaneous push and pop when 0 < count < DEPTH, with data order preserved.
REQ-023 SHALL have a latency of one cycle from push to out_valid in the non-bypass build.
REQ-024 SHALL, on flush high at a clk edge, take priority over all other events: count, read pointer and write pointer go to 0; any same-cycle push and pop is discarded.
REQ-025 SHALL hold every entry and output stable while out_ready is low (stall), except under flush.
REQ-026 SHALL never overflow or underflow; pushes while full and pops while empty are impossible by construction.

Reset
REQ-027 SHALL, while reset is high, asynchronously force count=0, both pointers=0, out_valid=0, out_pc=0 and out_instr=32'h00000013.
REQ-028 SHALL force in_ready=0 while reset is high, and go to 1 in the first cycle after reset deasserts.
REQ-029 SHALL discard all queued data on reset asserted mid-operation; storage array contents need not be cleared.

Configuration
REQ-030 SHALL support the macro FETCH_QUEUE_BYPASS_EN.
REQ-031 With FETCH_QUEUE_BYPASS_EN defined: when count==0, in_valid=1 and flush=0, the block SHALL drive out_valid=1, out_pc=in_pc and out_instr=in_instr combinationally in the same cycle; if out_ready is also 1, the instruction is consumed without being stored and count stays 0.
REQ-032 Without FETCH_QUEUE_BYPASS_EN: there SHALL be no combinational path from the in_* ports to the out_* ports, and latency SHALL be one cycle.

Verification
REQ-033 SHALL cover this scenario: reset, then push PC 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> outputs 0x0,0x4,0x8,0xC in order on consecutive cycles, then out_valid=0 with out_instr=0x00000013.
REQ-034 SHALL cover this scenario: continuous in_valid=1 and out_ready=1 at count=2 -> count stays 2, and every PC comes out exactly once, in order.
REQ-035 SHALL cover this scenario: count=3 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the flushed PC never appears at the output.
REQ-036 SHALL cover this scenario: reset asserted mid-cycle with count=2 -> out_valid=0 immediately without waiting for a clk edge; after release, count=0 and in_ready=1.
REQ-037 SHALL cover this scenario: with FETCH_QUEUE_BYPASS_EN and an empty queue, in_pc=0x100 with out_ready=1 -> out_pc=0x100 in the same cycle and count stays 0; without the macro, out_pc=0x100 appears the next cycle.
REQ-038 SHALL cover this scenario: pointer wrap, 10 push/pop cycles at DEPTH=4 -> correct order is preserved across wrap-around.
